mvm_stream_engine: RTL and testbench

//  Parametrised successor of the UART MVM core: byte-stream matrix-vector engine computing y = K*x.

---
 rtl/mvm_stream_pkg.sv | 36 +++
 rtl/mvm_stream_if.sv | 11 +
 rtl/mvm_stream_engine_mac.sv | 49 ++++
 rtl/mvm_stream_engine.sv | 137 +++++++++++++
 tb/tb_mvm_stream_engine.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mvm_stream_pkg.sv
// Shared command codes, FSM state encoding and output saturation helper
// for the byte-stream matrix-vector engine.
package mvm_stream_pkg;

   localparam logic [7:0] CMD_LOAD_K = 8'h01;
   localparam logic [7:0] CMD_LOAD_X = 8'h02;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_K  = 3'd1,
      LOAD_X  = 3'd2,
      COMPUTE = 3'd3,
      SEND    = 3'd4
   } state_t;

   // Clamp an accumulator (already sign- or zero-extended to 64 bits) into
   // a w_y-bit result; the caller keeps the low w_y bits of the return value.
   function automatic logic [63:0] sat_y(input logic [63:0] acc, input logic is_signed,
                                         input int w_y);
      longint v;
      longint hi;
      longint lo;
      v = longint'(acc);
      if (is_signed) begin
         hi = (64'sd1 <<< (w_y - 1)) - 64'sd1;
         lo = -hi - 64'sd1;
         if (v > hi) v = hi;
         else if (v < lo) v = lo;
      end else begin
         hi = (64'sd1 <<< w_y) - 64'sd1;
         if (acc > 64'(hi)) v = hi;
      end
      return 64'(v);
   endfunction

endpackage

// File: rtl/mvm_stream_if.sv
// Word stream with valid/ready handshake (UART RX/TX side of the engine).
interface mvm_stream_if #(
   parameter int BITS_PER_WORD = 8
) ();
   logic [BITS_PER_WORD-1:0] data;
   logic                     valid;
   logic                     ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/mvm_stream_engine_mac.sv
// Multiply-accumulate with per-row clear and saturated row result.
// y reflects the accumulator including the current product, so the top
// can store it on the last column of a row.
module mvm_mac_sat
   import mvm_stream_pkg::*;
#(
   parameter int W_X     = 4,
   parameter int W_K     = 4,
   parameter int W_ACC   = 10,
   parameter int W_Y_OUT = 8,
   parameter int SIGNED  = 1
) (
   input  logic               clk,
   input  logic               en,
   input  logic               row_start,
   input  logic [W_X-1:0]     x,
   input  logic [W_K-1:0]     k,
   output logic [W_Y_OUT-1:0] y
);

   logic [W_ACC-1:0] x_ext;
   logic [W_ACC-1:0] k_ext;
   logic [W_ACC-1:0] prod;
   logic [W_ACC-1:0] acc;
   logic [W_ACC-1:0] acc_next;
   logic [63:0]      acc_wide;

   // Extend operands, multiply, accumulate and saturate the running sum
   always_comb begin
      if (SIGNED != 0) begin
         x_ext    = W_ACC'($signed(x));
         k_ext    = W_ACC'($signed(k));
      end else begin
         x_ext    = W_ACC'(x);
         k_ext    = W_ACC'(k);
      end
      prod     = x_ext * k_ext;
      acc_next = (row_start ? '0 : acc) + prod;
      if (SIGNED != 0) acc_wide = 64'($signed(acc_next));
      else             acc_wide = 64'(acc_next);
      y        = W_Y_OUT'(sat_y(acc_wide, SIGNED != 0, W_Y_OUT));
   end

   // Accumulator advances only while the engine is computing
   always_ff @(posedge clk) begin
      if (en) acc <= acc_next;
   end

endmodule

// File: rtl/mvm_stream_engine.sv
// Byte-stream matrix-vector engine: y = K*x with command decode, K reuse,
// signed/unsigned arithmetic and saturated outputs.
module mvm_stream_engine
   import mvm_stream_pkg::*;
#(
   parameter int R             = 2,
   parameter int C             = 2,
   parameter int W_X           = 4,
   parameter int W_K           = 4,
   parameter int W_Y_OUT       = 8,
   parameter int BITS_PER_WORD = 8,
   parameter int SIGNED        = 1
) (
   input  logic         clk,
   input  logic         rst,
   mvm_stream_if.slave  s,
   mvm_stream_if.master m,
   output logic         busy,
   output logic         err_cmd
);

   localparam int RC    = R * C;
   localparam int EW    = (RC > 1) ? $clog2(RC) : 1;
   localparam int CW    = (C > 1) ? $clog2(C) : 1;
   localparam int RW    = (R > 1) ? $clog2(R) : 1;
   localparam int W_ACC = W_X + W_K + $clog2(C) + 1;

   state_t                   state, state_next;
   logic                     s_ready, m_valid, k_loaded;
   logic [BITS_PER_WORD-1:0] m_data;
   logic [EW-1:0]            k_idx, e_idx;
   logic [CW-1:0]            x_idx, col;
   logic [RW-1:0]            row, send_idx;
   logic [W_K-1:0]           k_mem [RC];
   logic [W_X-1:0]           x_mem [C];
   logic [W_Y_OUT-1:0]       y_buf [R];
   logic [W_Y_OUT-1:0]       y_mac;
   logic s_fire, m_fire, cmd_ok, k_last, x_last, e_last, col_last, send_last;

   function automatic logic [BITS_PER_WORD-1:0] ext_y(input logic [W_Y_OUT-1:0] v);
      if (SIGNED != 0) return BITS_PER_WORD'($signed(v));
      else             return BITS_PER_WORD'(v);
   endfunction

   assign s.ready = s_ready;
   assign m.valid = m_valid;
   assign m.data  = m_data;
   assign busy    = (state != IDLE);

   mvm_mac_sat #(
      .W_X(W_X), .W_K(W_K), .W_ACC(W_ACC), .W_Y_OUT(W_Y_OUT), .SIGNED(SIGNED)
   ) u_mac (
      .clk(clk), .en(state == COMPUTE), .row_start(col == '0),
      .x(x_mem[col]), .k(k_mem[e_idx]), .y(y_mac)
   );

   // Handshake qualifiers, last-element flags and next-state decode
   always_comb begin
      s_fire     = s.valid & s_ready;
      m_fire     = m_valid & m.ready;
      cmd_ok     = (s.data == BITS_PER_WORD'(CMD_LOAD_K)) ||
                   ((s.data == BITS_PER_WORD'(CMD_LOAD_X)) && k_loaded);
      k_last     = (k_idx == EW'(RC - 1));
      x_last     = (x_idx == CW'(C - 1));
      e_last     = (e_idx == EW'(RC - 1));
      col_last   = (col == CW'(C - 1));
      send_last  = (send_idx == RW'(R - 1));
      state_next = state;
      case (state)
         IDLE:    if (s_fire && cmd_ok)
                     state_next = (s.data == BITS_PER_WORD'(CMD_LOAD_K)) ? LOAD_K : LOAD_X;
         LOAD_K:  if (s_fire && k_last) state_next = LOAD_X;
         LOAD_X:  if (s_fire && x_last) state_next = COMPUTE;
         COMPUTE: if (e_last) state_next = SEND;
         SEND:    if (m_fire && send_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Control state, counters, K storage and output handshake registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         s_ready  <= 1'b0;
         m_valid  <= 1'b0;
         m_data   <= '0;
         err_cmd  <= 1'b0;
         k_loaded <= 1'b0;
         k_idx    <= '0;
         x_idx    <= '0;
         e_idx    <= '0;
         col      <= '0;
         row      <= '0;
         send_idx <= '0;
         for (int i = 0; i < RC; i++) k_mem[i] <= '0;
      end else begin
         state   <= state_next;
         s_ready <= (state_next == IDLE) || (state_next == LOAD_K) || (state_next == LOAD_X);
         err_cmd <= (state == IDLE) && s_fire && !cmd_ok;
         case (state)
            LOAD_K: if (s_fire) begin
               k_mem[k_idx] <= s.data[W_K-1:0];
               k_idx        <= k_last ? '0 : k_idx + EW'(1);
               if (k_last) k_loaded <= 1'b1;
            end
            LOAD_X: if (s_fire) x_idx <= x_last ? '0 : x_idx + CW'(1);
            COMPUTE: begin
               e_idx <= e_last ? '0 : e_idx + EW'(1);
               col   <= col_last ? '0 : col + CW'(1);
               if (col_last) row <= e_last ? '0 : row + RW'(1);
            end
            SEND: begin
               if (!m_valid) begin
                  m_valid <= 1'b1;
                  m_data  <= ext_y(y_buf[send_idx]);
               end else if (m.ready) begin
                  if (send_last) begin
                     m_valid  <= 1'b0;
                     send_idx <= '0;
                  end else begin
                     m_data   <= ext_y(y_buf[send_idx + RW'(1)]);
                     send_idx <= send_idx + RW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Data storage for x and the saturated row results
   always_ff @(posedge clk) begin
      if (state == LOAD_X && s_fire) x_mem[x_idx] <= s.data[W_X-1:0];
      if (state == COMPUTE && col_last) y_buf[row] <= y_mac;
   end

endmodule

// File: tb/tb_mvm_stream_engine.sv
// Scoreboard bench: one unsigned and one signed engine driven in lockstep
// with the same byte stream; each has its own queue of expected words.
module tb_mvm_stream_engine;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] drv_data = 8'h00;
   logic       drv_valid = 1'b0;
   logic       drv_mready = 1'b1;
   logic       busy_u, busy_s, err_u, err_s;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] qu[$];
   logic [7:0] qs[$];

   mvm_stream_if #(.BITS_PER_WORD(8)) su_if ();
   mvm_stream_if #(.BITS_PER_WORD(8)) mu_if ();
   mvm_stream_if #(.BITS_PER_WORD(8)) ss_if ();
   mvm_stream_if #(.BITS_PER_WORD(8)) ms_if ();

   assign su_if.data  = drv_data;
   assign su_if.valid = drv_valid;
   assign ss_if.data  = drv_data;
   assign ss_if.valid = drv_valid;
   assign mu_if.ready = drv_mready;
   assign ms_if.ready = drv_mready;

   mvm_stream_engine #(.R(2), .C(2), .W_X(4), .W_K(4), .W_Y_OUT(8), .BITS_PER_WORD(8), .SIGNED(0))
      dut_u (.clk(clk), .rst(rst), .s(su_if), .m(mu_if), .busy(busy_u), .err_cmd(err_u));
   mvm_stream_engine #(.R(2), .C(2), .W_X(4), .W_K(4), .W_Y_OUT(8), .BITS_PER_WORD(8), .SIGNED(1))
      dut_s (.clk(clk), .rst(rst), .s(ss_if), .m(ms_if), .busy(busy_s), .err_cmd(err_s));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
      end
   endtask

   // Monitor: a word is consumed when valid and ready meet at the next edge
   always @(negedge clk) begin
      if (!rst && drv_mready) begin
         if (mu_if.valid) begin
            if (qu.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL out_u: got unexpected word 0x%02h, expected none", mu_if.data);
            end else chk("out_u", mu_if.data, qu.pop_front());
         end
         if (ms_if.valid) begin
            if (qs.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL out_s: got unexpected word 0x%02h, expected none", ms_if.data);
            end else chk("out_s", ms_if.data, qs.pop_front());
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic put(input logic [7:0] b);
      int n = 0;
      drv_data  = b;
      drv_valid = 1'b1;
      while (!su_if.ready && n < 100) begin step(1); n++; end
      if (n >= 100) begin
         n_cmp++; n_bad++;
         $display("FAIL put_timeout: s_ready low %0d cycles for byte 0x%02h, expected high", n, b);
      end else begin
         @(posedge clk); #1;
      end
      drv_valid = 1'b0;
   endtask

   task automatic run(input logic [7:0] cmd, input logic [7:0] v[6]);
      put(cmd);
      for (int i = 0; i < 6; i++) put(v[i]);
   endtask

   task automatic expect_out(input logic [7:0] u0, u1, s0, s1);
      qu.push_back(u0); qu.push_back(u1);
      qs.push_back(s0); qs.push_back(s1);
   endtask

   task automatic drain();
      int n = 0;
      while ((qu.size() != 0 || qs.size() != 0 || busy_u || busy_s) && n < 200) begin
         step(1); n++;
      end
      if (n >= 200) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: got %0d/%0d words pending, expected 0", qu.size(), qs.size());
      end
   endtask

   initial begin
      logic [7:0] v_basic[6] = '{8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6};
      logic [7:0] v_sgn[6]   = '{8'hF, 8'h2, 8'hD, 8'h4, 8'h7, 8'hF};
      logic [7:0] v_eight[6] = '{8'h8, 8'h8, 8'h8, 8'h8, 8'h8, 8'h8};
      logic [7:0] v_full[6]  = '{8'hF, 8'hF, 8'hF, 8'hF, 8'hF, 8'hF};
      int acc_cyc;
      int n;

      // Reset state
      step(3);
      chk("rst_s_ready", {7'd0, su_if.ready}, 8'h0);
      chk("rst_m_valid", {7'd0, mu_if.valid}, 8'h0);
      chk("rst_m_data", mu_if.data, 8'h00);
      chk("rst_busy", {7'd0, busy_u}, 8'h0);
      chk("rst_err", {7'd0, err_s}, 8'h0);
      rst = 1'b0;

      // Basic product and first-output latency
      expect_out(8'h11, 8'h27, 8'h11, 8'h27);
      run(8'h01, v_basic);
      acc_cyc = cyc;
      n = 0;
      while (!mu_if.valid && n < 50) begin step(1); n++; end
      chk("latency", 8'(cyc - acc_cyc), 8'd5);
      drain();

      // Weight reuse
      expect_out(8'h03, 8'h07, 8'h03, 8'h07);
      put(8'h02); put(8'h1); put(8'h1);
      drain();

      // Mixed-sign operands
      expect_out(8'h87, 8'h97, 8'hF7, 8'hE7);
      run(8'h01, v_sgn);
      drain();

      // Saturation
      expect_out(8'h80, 8'h80, 8'h7F, 8'h7F);
      run(8'h01, v_eight);
      drain();
      expect_out(8'hFF, 8'hFF, 8'h02, 8'h02);
      run(8'h01, v_full);
      drain();

      // Backpressure: output held stable while m_ready is low
      drv_mready = 1'b0;
      expect_out(8'h11, 8'h27, 8'h11, 8'h27);
      run(8'h01, v_basic);
      n = 0;
      while (!mu_if.valid && n < 50) begin step(1); n++; end
      for (int i = 0; i < 20; i++) begin
         chk("bp_data_u", mu_if.data, 8'h11);
         chk("bp_valid_s", {7'd0, ms_if.valid}, 8'h1);
         step(1);
      end
      drv_mready = 1'b1;
      drain();

      // Illegal command
      put(8'h55);
      chk("ill_err_u", {7'd0, err_u}, 8'h1);
      chk("ill_busy", {7'd0, busy_u}, 8'h0);
      step(1);
      chk("ill_err_clear", {7'd0, err_s}, 8'h0);

      // Reset clears stored K, so a reuse command is rejected
      rst = 1'b1; step(1); rst = 1'b0;
      chk("rst2_busy", {7'd0, busy_u}, 8'h0);
      put(8'h02);
      chk("noK_err_u", {7'd0, err_u}, 8'h1);
      chk("noK_err_s", {7'd0, err_s}, 8'h1);
      chk("noK_ready", {7'd0, su_if.ready}, 8'h1);
      step(1);
      chk("noK_err_clear", {7'd0, err_u}, 8'h0);
      chk("noK_busy", {7'd0, busy_s}, 8'h0);
      step(10);
      chk("noK_ready_hold", {7'd0, su_if.ready}, 8'h1);

      // Reset in the middle of LOAD_X
      put(8'h01);
      for (int i = 0; i < 5; i++) put(v_basic[i]);
      rst = 1'b1; step(1); rst = 1'b0;
      chk("midrst_busy", {7'd0, busy_u}, 8'h0);
      chk("midrst_valid", {7'd0, mu_if.valid}, 8'h0);
      step(10);
      chk("midrst_valid_later", {7'd0, ms_if.valid}, 8'h0);
      expect_out(8'h11, 8'h27, 8'h11, 8'h27);
      run(8'h01, v_basic);
      drain();

      chk("q_left_u", 8'(qu.size()), 8'd0);
      chk("q_left_s", 8'(qs.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
